audio_sample_streamer: RTL

//  Downstream of the flash sample fetcher, upstream of audio_codec. Buffers 32-bit flash words
//  (two signed 16-bit samples, [15:0] played first), unpacks them, applies playback-rate mode
//  and volume attenuation, and drives the codec write handshake (write_s / write_ready).

---
 rtl/audio_sample_streamer_if.sv | 33 +++
 rtl/audio_sample_streamer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_streamer_if.sv
// Bundle for the audio_sample_streamer. It carries three groups of signals:
//   - the upstream word stream (word_valid, word_data, word_ready),
//   - the playback mode,
//   - the codec write handshake, plus an underrun pulse and a debug view of the FSM state.
//
// Handshake rules:
//   - Upstream: a word transfers on a rising clock edge when word_valid and word_ready are both 1.
//   - Codec: the streamer raises write_s only after it has seen write_ready=1. It holds write_s and
//     writedata_* stable until the codec drops write_ready, which marks the sample as taken.
interface audio_sample_streamer_if;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic [1:0]  mode;
    logic        write_ready;
    logic        write_s;
    logic [15:0] writedata_left;
    logic [15:0] writedata_right;
    logic        underrun;
    logic [1:0]  state_dbg;

    // Streamer side
    modport master (
        input  word_valid, word_data, mode, write_ready,
        output word_ready, write_s, writedata_left, writedata_right, underrun, state_dbg
    );

    // Environment side (upstream fetcher plus codec)
    modport slave (
        output word_valid, word_data, mode, write_ready,
        input  word_ready, write_s, writedata_left, writedata_right, underrun, state_dbg
    );
endinterface

// File: rtl/audio_sample_streamer.sv
// audio_sample_streamer
//
// Buffers 32-bit flash words in a small FIFO and splits each word into two signed 16-bit samples,
// playing [15:0] first. Each sample is attenuated by 2**SHIFT, rounding toward zero, and then
// driven to the codec. The same sample goes to both the left and right channels.
//
// Optional feature: define STREAMER_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module audio_sample_streamer #(
    parameter int SHIFT      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    audio_sample_streamer_if.master bus
`ifdef STREAMER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             underrun_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [16:0] BIAS = 17'((1 << SHIFT) - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_READY  = 2'd1,
        S_SEND        = 2'd2,
        S_WAIT_ACCEPT = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full, fifo_empty, push, pop;

    // Playback state
    state_t        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [1:0]    mode_q, mode_d;
    logic [31:0]   hold_q, hold_d;
    logic [1:0]    last_idx;
    logic          sel_hi;
    logic [15:0]   sample;
    logic signed [16:0] sample_ext, biased, shifted;
    logic [15:0]   atten;
    logic [15:0]   writedata_q, writedata_d;
    logic          write_s_q, write_s_d;
    logic          underrun_q, underrun_d;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus.word_valid & ~fifo_full;

    // Fast mode plays only sample 0 of each word.
    // Slow mode plays four samples per word: lo, lo, hi, hi.
    // Normal mode (00 or 11) plays lo, then hi.
    always_comb begin
        unique case (mode_q)
            2'b01:   last_idx = 2'd0;
            2'b10:   last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
    end

    // Pick the current half-word and attenuate it. Negative values are biased up by
    // 2**SHIFT-1 before the arithmetic shift, so the result rounds toward zero.
    always_comb begin
        sel_hi     = (mode_q == 2'b10) ? idx_q[1] : idx_q[0];
        sample     = sel_hi ? hold_q[31:16] : hold_q[15:0];
        sample_ext = {sample[15], sample};
        biased     = sample_ext + (sample[15] ? BIAS : 17'sd0);
        shifted    = biased >>> SHIFT;
        atten      = shifted[15:0];
    end

    // Next-state logic for the playback FSM. This block also decides when to pop the FIFO.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        hold_d      = hold_q;
        pop         = 1'b0;
        underrun_d  = 1'b0;
        writedata_d = writedata_q;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = mem_q[rd_ptr_q];
                    mode_d  = bus.mode;
                    idx_d   = 2'd0;
                    state_d = S_WAIT_READY;
                end
            end
            S_WAIT_READY: begin
                if (bus.write_ready) state_d = S_SEND;
            end
            S_SEND: begin
                writedata_d = atten;
                state_d     = S_WAIT_ACCEPT;
            end
            S_WAIT_ACCEPT: begin
                if (!bus.write_ready) begin
                    if (idx_q != last_idx) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_WAIT_READY;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        hold_d  = mem_q[rd_ptr_q];
                        mode_d  = bus.mode;
                        idx_d   = 2'd0;
                        state_d = S_WAIT_READY;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        write_s_d = (state_d == S_WAIT_ACCEPT);
    end

    // Next FIFO occupancy. When a push and a pop land on the same edge, the count is unchanged.
    always_comb begin
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO word storage. It has no reset because entries are only read while the count is nonzero.
    always_ff @(posedge CLOCK_50) begin
        if (push) mem_q[wr_ptr_q] <= bus.word_data;
    end

    // Registered FIFO pointers, FSM state, and codec-facing outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            idx_q       <= '0;
            mode_q      <= '0;
            hold_q      <= '0;
            writedata_q <= '0;
            write_s_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            writedata_q <= writedata_d;
            write_s_q   <= write_s_d;
            underrun_q  <= underrun_d;
        end
    end

`ifdef STREAMER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    // Saturating count of underrun pulses. Only reset clears it.
    always_ff @(posedge CLOCK_50) begin
        if (reset)                                  ucnt_q <= '0;
        else if (underrun_d && ucnt_q != 16'hFFFF)  ucnt_q <= ucnt_q + 16'd1;
    end

    assign underrun_count = ucnt_q;
`endif

    assign bus.word_ready      = ~fifo_full;
    assign bus.write_s         = write_s_q;
    assign bus.writedata_left  = writedata_q;
    assign bus.writedata_right = writedata_q;
    assign bus.underrun        = underrun_q;
    assign bus.state_dbg       = state_q;
endmodule
